// File: rtl/dout_unpack_pkg.sv
// rtl/dout_unpack_pkg.sv - shared widths, FSM state and beat-counter types for dout_unpacker
// Purpose: single source of the stream widths and types used by every dout_unpack file.
// Ports: none (package).
package dout_unpack_pkg;

  localparam int WORD_W    = 32;
  localparam int IN_W      = 256;
  localparam int NUM_BEATS = IN_W / WORD_W;
  localparam int CNT_W     = $clog2(NUM_BEATS + 1);
  localparam int IDX_W     = $clog2(NUM_BEATS);

  typedef logic [CNT_W-1:0] beat_cnt_t;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

endpackage

// File: rtl/dout_unpack_if.sv
// rtl/dout_unpack_if.sv - vld/busy stream interface used on both sides of dout_unpacker
// Purpose: one stream of W-bit words with valid, backpressure and end-of-packet marker.
// Ports: vld (master->slave), data (master->slave), last (master->slave), busy (slave->master).
interface dout_unpack_if #(
  parameter int W = 32
);

  logic         vld;
  logic         busy;
  logic         last;
  logic [W-1:0] data;

  modport master(output vld, output data, output last, input busy);
  modport slave (input vld, input data, input last, output busy);

endinterface

// File: rtl/dout_unpack_xor.sv
// rtl/dout_unpack_xor.sv - running XOR of transferred data beats for the checksum beat
// Purpose: registered XOR accumulator, cleared when a new word loads.
// Ports: clk, rst (async, active-high), clear (new word loaded), en (data beat transfers),
//        word (beat being transferred), acc (XOR of data beats transferred so far).
module dout_unpack_xor
  import dout_unpack_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              en,
  input  logic [WORD_W-1:0] word,
  output logic [WORD_W-1:0] acc
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc ^ word;
    end
  end

endmodule

// File: rtl/dout_unpacker.sv
// rtl/dout_unpacker.sv - replays one 256-bit result word as eight 32-bit beats
// Purpose: accept an IN_W word on in_s, emit NUM_BEATS WORD_W beats on out_m (LSB word
//          first) with last on the final beat; the next word may load on the final beat's
//          transfer edge so packets stream without a bubble.
// Optional feature: DOUT_UNPACK_CHECKSUM_EN appends a ninth beat holding the XOR of the
//          eight data words, and last moves to that beat.
// Ports: clk, rst (async, active-high), in_s (slave: vld/data in, busy out),
//        out_m (master: vld/data/last out, busy in).
module dout_unpacker
  import dout_unpack_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  dout_unpack_if.slave  in_s,
  dout_unpack_if.master out_m
);

`ifdef DOUT_UNPACK_CHECKSUM_EN
  localparam beat_cnt_t LAST_BEAT = beat_cnt_t'(NUM_BEATS);
`else
  localparam beat_cnt_t LAST_BEAT = beat_cnt_t'(NUM_BEATS - 1);
`endif

  state_t            state;
  beat_cnt_t         cnt;
  logic [IN_W-1:0]   buf_q;

  logic              last_beat;
  logic              in_xfer;
  logic              out_xfer;
  beat_cnt_t         cnt_nxt;
  logic [IDX_W-1:0]  idx_nxt;
  logic [WORD_W-1:0] word_nxt;

  assign last_beat = (cnt == LAST_BEAT);

  // Ready for a new word in IDLE, or in SEND only when the final beat leaves this edge.
  assign in_s.busy = rst || (state == SEND && !(last_beat && !out_m.busy));
  assign in_xfer   = in_s.vld && !in_s.busy;
  assign out_xfer  = out_m.vld && !out_m.busy;

  assign cnt_nxt = cnt + beat_cnt_t'(1);
  // Truncation only aliases on the checksum index, which word_nxt never reads from buf_q.
  assign idx_nxt = cnt_nxt[IDX_W-1:0];

`ifdef DOUT_UNPACK_CHECKSUM_EN
  logic [WORD_W-1:0] acc;

  // Checksum beat itself is excluded: only data beats feed the accumulator.
  dout_unpack_xor u_xor (
    .clk   (clk),
    .rst   (rst),
    .clear (in_xfer),
    .en    (out_xfer && !last_beat),
    .word  (out_m.data),
    .acc   (acc)
  );

  // acc excludes the beat leaving now, so fold it in for the checksum value.
  assign word_nxt = (cnt_nxt == beat_cnt_t'(NUM_BEATS)) ? (acc ^ out_m.data)
                                                        : buf_q[WORD_W*idx_nxt +: WORD_W];
`else
  assign word_nxt = buf_q[WORD_W*idx_nxt +: WORD_W];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      buf_q      <= '0;
      out_m.vld  <= 1'b0;
      out_m.last <= 1'b0;
      out_m.data <= '0;
    end else if (in_xfer) begin
      // Covers both a load from IDLE and the zero-bubble reload on the final beat.
      state      <= SEND;
      cnt        <= '0;
      buf_q      <= in_s.data;
      out_m.vld  <= 1'b1;
      out_m.last <= (LAST_BEAT == '0);
      out_m.data <= in_s.data[WORD_W-1:0];
    end else if (out_xfer) begin
      if (last_beat) begin
        state      <= IDLE;
        out_m.vld  <= 1'b0;
        out_m.last <= 1'b0;
      end else begin
        cnt        <= cnt_nxt;
        out_m.data <= word_nxt;
        out_m.last <= (cnt_nxt == LAST_BEAT);
      end
    end
  end

endmodule

// File: tb/tb_dout_unpacker.sv
// tb/tb_dout_unpacker.sv - self-checking bench for dout_unpacker
module tb_dout_unpacker;
  import dout_unpack_pkg::*;

`ifdef DOUT_UNPACK_CHECKSUM_EN
  localparam int PKT = NUM_BEATS + 1;
`else
  localparam int PKT = NUM_BEATS;
`endif

  typedef struct packed {
    logic [WORD_W-1:0] data;
    logic              last;
  } beat_t;

  typedef struct {
    logic [IN_W-1:0]   word;
    logic [15:0]       busy_pat;
    logic [WORD_W-1:0] exp_first;
    logic [WORD_W-1:0] exp_final;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dout_unpack_if #(.W(IN_W))   in_if ();
  dout_unpack_if #(.W(WORD_W)) out_if ();

  dout_unpacker dut (
    .clk   (clk),
    .rst   (rst),
    .in_s  (in_if.slave),
    .out_m (out_if.master)
  );

  int errors = 0;
  int checks = 0;
  int beats_seen = 0;
  int accepted = 0;
  beat_t sb[$];
  logic [WORD_W-1:0] first_seen, final_seen, prev_data;
  logic new_pkt = 1'b1;
  logic prev_hold = 1'b0;
  logic prev_last;

  task automatic chk(input string name, input logic [IN_W-1:0] act, input logic [IN_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: beats are expected when a word is accepted, compared when they transfer.
  always @(negedge clk) begin
    beat_t e;
    logic [WORD_W-1:0] x;
    if (rst) begin
      new_pkt   = 1'b1;
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        chk("hold_vld", out_if.vld, 1'b1);
        chk("hold_data", out_if.data, prev_data);
        chk("hold_last", out_if.last, prev_last);
      end
      prev_hold = out_if.vld && out_if.busy;
      prev_data = out_if.data;
      prev_last = out_if.last;
      chk("in_busy_rule", in_if.busy, out_if.vld && !(out_if.last && !out_if.busy));
      if (out_if.vld && !out_if.busy) begin
        if (new_pkt) first_seen = out_if.data;
        new_pkt = out_if.last;
        if (out_if.last) final_seen = out_if.data;
        beats_seen++;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got %0h expected none", out_if.data);
        end else begin
          e = sb.pop_front();
          chk("beat_data", out_if.data, e.data);
          chk("beat_last", out_if.last, e.last);
        end
      end
      if (in_if.vld && !in_if.busy) begin
        accepted++;
        x = '0;
        for (int k = 0; k < NUM_BEATS; k++) begin
          e.data = in_if.data[k*WORD_W +: WORD_W];
          e.last = (k == PKT - 1);
          x ^= e.data;
          sb.push_back(e);
        end
`ifdef DOUT_UNPACK_CHECKSUM_EN
        e.data = x;
        e.last = 1'b1;
        sb.push_back(e);
`endif
      end
    end
  end

  task automatic wait_accept(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (in_if.busy && n < 500);
    if (in_if.busy) begin
      checks++;
      errors++;
      $display("FAIL %s: accept timeout got busy=1 expected busy=0", name);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((sb.size() != 0 || out_if.vld) && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({name, "_drained"}, sb.size(), 0);
  endtask

  vec_t vecs[3];

  initial begin
    int b0, a0, n;
    logic sent;

    vecs[0] = '{256'h00000008_00000007_00000006_00000005_00000004_00000003_00000002_00000001,
                16'h0000, 32'h00000001, 32'h00000008};
`ifdef DOUT_UNPACK_CHECKSUM_EN
    vecs[1] = '{{192'h0, 32'h0000FFFF, 32'hFFFF0000}, 16'b01101, 32'hFFFF0000, 32'hFFFFFFFF};
    vecs[2] = '{256'h80000000_00000001_12345678_12345678_F0F0F0F0_0F0F0F0F_5A5A5A5A_A5A5A5A5,
                16'hAAAA, 32'hA5A5A5A5, 32'h80000001};
`else
    vecs[1] = '{{192'h0, 32'h0000FFFF, 32'hFFFF0000}, 16'b01101, 32'hFFFF0000, 32'h00000000};
    vecs[2] = '{256'h80000000_00000001_12345678_12345678_F0F0F0F0_0F0F0F0F_5A5A5A5A_A5A5A5A5,
                16'hAAAA, 32'hA5A5A5A5, 32'h80000000};
`endif

    rst         = 1'b1;
    in_if.vld   = 1'b0;
    in_if.data  = '0;
    in_if.last  = 1'b0;
    out_if.busy = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_in_busy", in_if.busy, 1'b1);
    chk("rst_out_vld", out_if.vld, 1'b0);
    chk("rst_out_last", out_if.last, 1'b0);
    chk("rst_out_data", out_if.data, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_busy", in_if.busy, 1'b0);

    // Table-driven packets with per-cycle out_busy patterns.
    for (int v = 0; v < 3; v++) begin
      b0 = beats_seen;
      in_if.data  = vecs[v].word;
      in_if.vld   = 1'b1;
      out_if.busy = vecs[v].busy_pat[0];
      n = 0;
      while ((in_if.vld || sb.size() != 0 || out_if.vld) && n < 300) begin
        @(negedge clk);
        sent = in_if.vld && !in_if.busy;
        @(posedge clk);
        #1;
        if (sent) in_if.vld = 1'b0;
        n++;
        out_if.busy = vecs[v].busy_pat[n % 16];
      end
      out_if.busy = 1'b0;
      chk("vec_done", n < 300, 1'b1);
      chk("vec_beats", beats_seen - b0, PKT);
      chk("vec_first", first_seen, vecs[v].exp_first);
      chk("vec_final", final_seen, vecs[v].exp_final);
      chk("vec_idle_vld", out_if.vld, 1'b0);
      chk("vec_idle_busy", in_if.busy, 1'b0);
    end

    // Back-to-back words: no gap, in_busy low only while the final beat is presented.
    b0 = beats_seen;
    in_if.data = vecs[0].word;
    in_if.vld  = 1'b1;
    wait_accept("b2b_first");
    in_if.data = vecs[2].word;
    for (int c = 0; c < 2 * PKT; c++) begin
      @(negedge clk);
      chk("b2b_vld", out_if.vld, 1'b1);
      chk("b2b_in_busy", in_if.busy, !(c == PKT - 1 || c == 2 * PKT - 1));
      if (c == PKT - 1) begin
        @(posedge clk);
        #1;
        in_if.vld = 1'b0;
      end
    end
    drain("b2b");
    chk("b2b_beats", beats_seen - b0, 2 * PKT);

    // Reset after beat 3: output drops at once, no stale beats afterwards.
    in_if.data = vecs[2].word;
    in_if.vld  = 1'b1;
    wait_accept("rst_mid");
    in_if.vld = 1'b0;
    b0 = beats_seen;
    n = 0;
    while (beats_seen - b0 < 3 && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_vld", out_if.vld, 1'b0);
    chk("async_rst_last", out_if.last, 1'b0);
    chk("async_rst_busy", in_if.busy, 1'b1);
    sb.delete();
    @(posedge clk);
    #2;
    rst = 1'b0;
    b0 = beats_seen;
    in_if.data = 256'h77770008_77770007_77770006_77770005_77770004_77770003_77770002_77770001;
    in_if.vld  = 1'b1;
    wait_accept("rst_fresh");
    in_if.vld = 1'b0;
    drain("rst_fresh");
    chk("rst_fresh_first", first_seen, 32'h77770001);
    chk("rst_fresh_beats", beats_seen - b0, PKT);

    // in_vld held with out_busy stuck high: exactly one word taken until busy clears.
    a0 = accepted;
    out_if.busy = 1'b1;
    in_if.data  = vecs[0].word;
    in_if.vld   = 1'b1;
    wait_accept("stall_first");
    in_if.data = vecs[1].word;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk("stall_in_busy", in_if.busy, 1'b1);
    end
    chk("stall_accepted", accepted - a0, 1);
    @(posedge clk);
    #1;
    out_if.busy = 1'b0;
    wait_accept("stall_second");
    in_if.vld = 1'b0;
    drain("stall");
    chk("stall_accepted_total", accepted - a0, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
